tmds_bit_serializer: RTL and testbench

Single-clock 10:1 serializer for one TMDS lane, with a combinational 8-bit ones-counter. It runs on the serial bit clock and shifts a 10-bit TMDS character out LSB-first. It emits a load strobe so the upstream encoder can present the next character, and reports the ones-count and DC disparity of the character currently being shifted. It sits between the per-channel TMDS encoder and the lane output pin. The encoder uses the ones-counter for its transition-minimisation and disparity decisions.

---
 rtl/tmds_bit_serializer.sv | 125 ++++++++++++
 tb/tb_tmds_bit_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_bit_serializer
//  Brief    : 10:1 LSB-first serializer for one TMDS lane, running on the
//             serial bit clock. Emits a one-cycle load strobe for the upstream
//             encoder, reports ones-count and DC disparity of the character
//             being shifted, and provides a standalone combinational 8-bit
//             ones-counter for the encoder's decisions.
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_bit_serializer (
   input  logic       serialClock,
   input  logic       resetN,
   input  logic [9:0] wordIn,
   input  logic [7:0] popcountIn,
   output logic [3:0] onesCount,
   output logic       serialOut,
   output logic       loadStrobe,
   output logic [3:0] bitIndex,
   output logic [3:0] wordOnes,
   output logic [4:0] wordDisparity
);

   // Last bit position of a character; the cycle showing it is the load cycle.
   localparam logic [3:0] C_LAST_INDEX  = 4'd9;
   // Character length used as the disparity offset (2*ones - 10).
   localparam logic [4:0] C_WORD_LEN    = 5'd10;
   // Disparity of a word with zero ones: -10 in 5-bit two's complement.
   localparam logic [4:0] C_DISP_RESET  = 5'b10110;

   // Counts the ones in a 10-bit character.
   function automatic logic [3:0] popcount10(input logic [9:0] value);
      logic [3:0] count;
      count = 4'd0;
      for (int i = 0; i < 10; i++) begin
         count = count + {3'b000, value[i]};
      end
      return count;
   endfunction

   // Counts the ones in a byte.
   function automatic logic [3:0] popcount8(input logic [7:0] value);
      logic [3:0] count;
      count = 4'd0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'b000, value[i]};
      end
      return count;
   endfunction

   // Registered state. The shift register only keeps the bits of the current
   // character that have not yet been sent: bit 0 goes straight to serialOut
   // at capture, so bits 9..1 are all that need storing.
   logic [3:0] bit_index_q,  bit_index_d;
   logic [8:0] shift_q,      shift_d;
   logic       serial_q,     serial_d;
   logic [3:0] word_ones_q,  word_ones_d;
   logic [4:0] word_disp_q,  word_disp_d;

   logic       load;
   logic [3:0] word_in_ones;

   // Load decode from the registered counter keeps the strobe glitch-free.
   assign load         = (bit_index_q == C_LAST_INDEX);
   assign word_in_ones = popcount10(wordIn);

   // Next-state: modulo-10 counter, capture on load, shift otherwise.
   always_comb begin
      bit_index_d = bit_index_q;
      shift_d     = shift_q;
      serial_d    = serial_q;
      word_ones_d = word_ones_q;
      word_disp_d = word_disp_q;

      if (load) begin
         bit_index_d = 4'd0;
      end else begin
         bit_index_d = bit_index_q + 4'd1;
      end

      if (load) begin
         // Capture: bit 0 goes out now, bits 9..1 wait in the shift register.
         serial_d    = wordIn[0];
         shift_d     = wordIn[9:1];
         word_ones_d = word_in_ones;
         // 2*ones - 10, computed modulo 32 so negatives come out as two's
         // complement (e.g. 0 ones gives 10110).
         word_disp_d = {word_in_ones, 1'b0} - C_WORD_LEN;
      end else begin
         // Shift: next remaining bit out, register moves one place down.
         serial_d    = shift_q[0];
         shift_d     = {1'b0, shift_q[8:1]};
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge serialClock or negedge resetN) begin
      if (!resetN) begin
         bit_index_q <= 4'd0;
         shift_q     <= 9'd0;
         serial_q    <= 1'b0;
         word_ones_q <= 4'd0;
         word_disp_q <= C_DISP_RESET;
      end else begin
         bit_index_q <= bit_index_d;
         shift_q     <= shift_d;
         serial_q    <= serial_d;
         word_ones_q <= word_ones_d;
         word_disp_q <= word_disp_d;
      end
   end

   // Standalone ones-counter: purely combinational, independent of reset.
   always_comb begin
      onesCount = popcount8(popcountIn);
   end

   assign serialOut     = serial_q;
   assign loadStrobe    = load;
   assign bitIndex      = bit_index_q;
   assign wordOnes      = word_ones_q;
   assign wordDisparity = word_disp_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_bit_serializer
//  Brief    : Scoreboard bench for tmds_bit_serializer. Stimulus pushes the
//             expected ten output cycles of every loaded character; a monitor
//             pops and compares once per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_bit_serializer;

   logic       serialClock = 1'b0;
   logic       resetN;
   logic [9:0] wordIn;
   logic [7:0] popcountIn;
   logic [3:0] onesCount;
   logic       serialOut;
   logic       loadStrobe;
   logic [3:0] bitIndex;
   logic [3:0] wordOnes;
   logic [4:0] wordDisparity;

   tmds_bit_serializer dut (
      .serialClock   (serialClock),
      .resetN        (resetN),
      .wordIn        (wordIn),
      .popcountIn    (popcountIn),
      .onesCount     (onesCount),
      .serialOut     (serialOut),
      .loadStrobe    (loadStrobe),
      .bitIndex      (bitIndex),
      .wordOnes      (wordOnes),
      .wordDisparity (wordDisparity)
   );

   always #5 serialClock = ~serialClock;

   typedef struct {
      logic       b;
      int         idx;
      int         ones;
      logic [4:0] disp;
   } exp_t;

   exp_t       exp_q[$];
   logic [9:0] words[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc;
   int         cyc_m = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Number of ones in the low 'width' bits of v.
   function automatic int ref_ones(input int v, input int width);
      int n;
      n = 0;
      for (int i = 0; i < width; i++) n += (v >> i) & 1;
      return n;
   endfunction

   // Each character is transmitted as ten cycles: bit k in the k-th cycle.
   task automatic push_expected(input logic [9:0] w);
      exp_t e;
      int   ones;
      ones = ref_ones(int'(w), 10);
      for (int k = 0; k < 10; k++) begin
         e.b    = w[k];
         e.idx  = k;
         e.ones = ones;
         e.disp = 5'(2 * ones - 10);
         exp_q.push_back(e);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " serialOut"},     int'(serialOut),     0);
      check({tag, " bitIndex"},      int'(bitIndex),      0);
      check({tag, " loadStrobe"},    int'(loadStrobe),    0);
      check({tag, " wordOnes"},      int'(wordOnes),      0);
      check({tag, " wordDisparity"}, int'(wordDisparity), int'(5'b10110));
   endtask

   // Monitor: sample 3 time units after each rising edge.
   always @(posedge serialClock) begin
      exp_t e;
      #3;
      if (!resetN) begin
         cyc_m = 0;
      end else begin
         cyc_m++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("serialOut",     int'(serialOut),     int'(e.b));
            check("bitIndex",      int'(bitIndex),      e.idx);
            check("loadStrobe",    int'(loadStrobe),    (e.idx == 9) ? 1 : 0);
            check("wordOnes",      int'(wordOnes),      e.ones);
            check("wordDisparity", int'(wordDisparity), int'(e.disp));
         end else begin
            // Nothing captured yet since reset release.
            check("idle serialOut",     int'(serialOut),     0);
            check("idle bitIndex",      int'(bitIndex),      cyc_m % 10);
            check("idle loadStrobe",    int'(loadStrobe),    (cyc_m % 10 == 9) ? 1 : 0);
            check("idle wordOnes",      int'(wordOnes),      0);
            check("idle wordDisparity", int'(wordDisparity), int'(5'b10110));
         end
      end
   end

   // Streams the queued words, one per load cycle, with random junk on wordIn
   // in every other cycle. With reset_mid set, asserts reset at bit 4 of the
   // last word; otherwise returns at the first load cycle with no word left.
   task automatic run_words(input bit reset_mid);
      bit         last_loaded;
      logic [9:0] w;
      logic [9:0] last_w;
      last_loaded = 1'b0;
      last_w      = '0;
      cyc         = 0;
      forever begin
         @(negedge serialClock);
         cyc++;
         popcountIn = 8'($urandom);
         #1;
         check("onesCount random", int'(onesCount), ref_ones(int'(popcountIn), 8));
         if (cyc % 10 == 9) begin
            if (words.size() > 0) begin
               w      = words.pop_front();
               wordIn = w;
               push_expected(w);
               last_w = w;
               if (words.size() == 0) last_loaded = 1'b1;
            end else begin
               return;
            end
         end else begin
            wordIn = 10'($urandom);
            if (reset_mid && last_loaded && (cyc % 10 == 4)) begin
               #1;
               check("pre-reset serialOut", int'(serialOut), int'(last_w[4]));
               resetN = 1'b0;
               #1;
               check_reset_values("async reset");
               exp_q.delete();
               repeat (2) @(negedge serialClock);
               #1 resetN = 1'b1;
               return;
            end
         end
      end
   endtask

   localparam int N_POP = 6;
   logic [7:0] pop_vec [N_POP] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h80, 8'h7F};
   int         pop_req [N_POP] = '{0, 8, 4, 1, 1, 7};

   initial begin
      resetN     = 1'b0;
      wordIn     = '0;
      popcountIn = '0;
      repeat (2) @(negedge serialClock);
      #2;
      check_reset_values("power-on reset");
      for (int i = 0; i < N_POP; i++) begin
         popcountIn = pop_vec[i];
         #1;
         check("onesCount directed", int'(onesCount), pop_req[i]);
      end
      @(negedge serialClock);
      #1 resetN = 1'b1;

      // Control token, back-to-back extremes, random words, then 0x155
      // interrupted by reset at bit 4.
      words.push_back(10'b1101010100);
      words.push_back(10'h3FF);
      words.push_back(10'h000);
      for (int i = 0; i < 4; i++) words.push_back(10'($urandom));
      words.push_back(10'h155);
      run_words(1'b1);

      // After release: idle for nine cycles, then a fresh stream.
      for (int i = 0; i < 3; i++) words.push_back(10'($urandom));
      words.push_back(10'h155);
      run_words(1'b0);

      // Freeze the DUT before the next capture edge and close out.
      #1 resetN = 1'b0;
      check("scoreboard drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
